pc_return_stack: RTL and testbench

- Upstream neighbour of the program counter: generates the 10-bit load value (PC_DIN) the PC takes when its load strobe is asserted.
- Holds a small hardware LIFO of return addresses for CALL/RET. Selects between branch immediate, stack top and interrupt vector.
- Sits between the control unit (PUSH/POP/PC_MUX_SEL) and the PC (PC_COUNT fed back in, PC_DIN out).

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_return_stack_if.sv | 29 ++
 rtl/pc_return_stack_lifo.sv | 100 ++++++++++
 rtl/pc_return_stack.sv | 54 +++++
 tb/tb_pc_return_stack.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared program-counter constants and the PC load-value select encoding.
package pc_pkg;

  localparam int          ADDR_W       = 10;
  localparam logic [9:0]  PC_RESET_VAL = 10'h001;
  localparam logic [9:0]  PC_WRAP_VAL  = 10'h001;
  localparam logic [9:0]  INTR_VEC     = 10'h3FF;

  typedef enum logic [1:0] {
    PC_SEL_IMM   = 2'b00,
    PC_SEL_STACK = 2'b01,
    PC_SEL_INTR  = 2'b10
  } pc_sel_t;

endpackage

// File: rtl/pc_return_stack_if.sv
// Control-unit / PC side signals of the return-address stack.
interface pc_return_stack_if #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] PC_COUNT;
  logic [ADDR_W-1:0] IMM_ADDR;
  logic [1:0]        PC_MUX_SEL;
  logic              PUSH;
  logic              POP;
  logic [ADDR_W-1:0] PC_DIN;
  logic              EMPTY;
  logic              FULL;
  logic [CNT_W-1:0]  COUNT;
  logic              OVF;
  logic              UNF;

  modport master (
    output PC_COUNT, IMM_ADDR, PC_MUX_SEL, PUSH, POP,
    input  PC_DIN, EMPTY, FULL, COUNT, OVF, UNF
  );

  modport slave (
    input  PC_COUNT, IMM_ADDR, PC_MUX_SEL, PUSH, POP,
    output PC_DIN, EMPTY, FULL, COUNT, OVF, UNF
  );
endinterface

// File: rtl/pc_return_stack_lifo.sv
// Return-address LIFO: storage, occupancy count and sticky overflow/underflow flags.
// With RAS_WRAP_EN defined, a push while full overwrites the oldest entry (circular storage).
module ras_lifo #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  top_idx, cnt_idx;

`ifdef RAS_WRAP_EN
  logic [PTR_W-1:0]  head_d;
`else
  assign head_q = '0;
`endif

  // Logical slot i lives at physical (head + i); head only moves in wrap mode.
  assign top_idx = head_q + PTR_W'(count_q - 1'b1);
  assign cnt_idx = head_q + PTR_W'(count_q);

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign top   = empty ? '0 : mem_q[top_idx];
  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`ifdef RAS_WRAP_EN
    head_d  = head_q;
`endif
    if (push && pop) begin
      if (empty) begin
        mem_d[cnt_idx] = push_data;
        count_d        = count_q + 1'b1;
        unf_d          = 1'b1;
      end else begin
        mem_d[top_idx] = push_data;
      end
    end else if (push) begin
      if (!full) begin
        mem_d[cnt_idx] = push_data;
        count_d        = count_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
`ifdef RAS_WRAP_EN
        mem_d[head_q] = push_data;
        head_d        = head_q + 1'b1;
`endif
      end
    end else if (pop) begin
      if (!empty) count_d = count_q - 1'b1;
      else        unf_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef RAS_WRAP_EN
      head_q  <= '0;
`endif
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef RAS_WRAP_EN
      head_q  <= head_d;
`endif
    end
  end

endmodule

// File: rtl/pc_return_stack.sv
// PC load-value generator: return-address adder, LIFO of return addresses and PC_DIN mux.
// Optional RAS_WRAP_EN makes push-while-full overwrite the oldest entry.
module pc_return_stack #(
  parameter int                     ADDR_W   = pc_pkg::ADDR_W,
  parameter int                     DEPTH    = 8,
  parameter logic [ADDR_W-1:0]      INTR_VEC = ADDR_W'(pc_pkg::INTR_VEC)
) (
  input  logic               CLK,
  input  logic               RST,
  pc_return_stack_if.slave   bus
);
  import pc_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] pc_din;
  logic [CNT_W-1:0]  count;

  // Matches the PC's own wrap: incrementing past the last address lands on 1, not 0.
  assign ret_addr = (bus.PC_COUNT == '1) ? ADDR_W'(PC_WRAP_VAL) : bus.PC_COUNT + 1'b1;

  ras_lifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (bus.PUSH),
    .pop       (bus.POP),
    .push_data (ret_addr),
    .top       (stack_top),
    .count     (count),
    .empty     (bus.EMPTY),
    .full      (bus.FULL),
    .ovf       (bus.OVF),
    .unf       (bus.UNF)
  );

  assign bus.COUNT = count;

  always_comb begin
    pc_din = bus.IMM_ADDR;
    case (pc_sel_t'(bus.PC_MUX_SEL))
      PC_SEL_STACK: pc_din = stack_top;
      PC_SEL_INTR:  pc_din = INTR_VEC;
      default:      pc_din = bus.IMM_ADDR;
    endcase
  end

  assign bus.PC_DIN = pc_din;

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench for pc_return_stack with a queue-based return-stack model.
module tb_pc_return_stack;

  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  int stk[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  pc_return_stack_if bus ();

  pc_return_stack dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int m_top();
    return (stk.size() > 0) ? stk[stk.size()-1] : 0;
  endfunction

  function automatic int m_pcdin(input logic [1:0] sel, input logic [9:0] imm);
    case (sel)
      2'b01:   return m_top();
      2'b10:   return 32'h3FF;
      default: return int'(imm);
    endcase
  endfunction

  task automatic model_update(input bit rst, input bit push, input bit pop, input logic [9:0] pc);
    int ret;
    ret = (pc == 10'h3FF) ? 1 : int'(pc) + 1;
    if (rst) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (push && pop) begin
      if (stk.size() == 0) begin
        stk.push_back(ret);
        m_unf = 1'b1;
      end else begin
        stk[stk.size()-1] = ret;
      end
    end else if (push) begin
      if (stk.size() < DEPTH) stk.push_back(ret);
      else begin
        m_ovf = 1'b1;
`ifdef RAS_WRAP_EN
        void'(stk.pop_front());
        stk.push_back(ret);
`endif
      end
    end else if (pop) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else m_unf = 1'b1;
    end
  endtask

  task automatic compare_all(input logic [1:0] sel, input logic [9:0] imm);
    check("count",  int'(bus.COUNT), stk.size());
    check("empty",  int'(bus.EMPTY), int'(stk.size() == 0));
    check("full",   int'(bus.FULL),  int'(stk.size() == DEPTH));
    check("ovf",    int'(bus.OVF),   int'(m_ovf));
    check("unf",    int'(bus.UNF),   int'(m_unf));
    check("pc_din", int'(bus.PC_DIN), m_pcdin(sel, imm));
  endtask

  // Called just after a falling edge; PC_DIN is checked before the rising edge
  // (zero-latency pre-pop top), state outputs after it.
  task automatic step(input bit rst, input bit push, input bit pop, input logic [1:0] sel,
                      input logic [9:0] pc, input logic [9:0] imm);
    RST            = rst;
    bus.PUSH       = push;
    bus.POP        = pop;
    bus.PC_MUX_SEL = sel;
    bus.PC_COUNT   = pc;
    bus.IMM_ADDR   = imm;
    #1;
    if (!rst) check("pc_din_pre", int'(bus.PC_DIN), m_pcdin(sel, imm));
    @(posedge CLK);
    model_update(rst, push, pop, pc);
    @(negedge CLK);
    compare_all(sel, imm);
  endtask

  initial begin
    bus.PUSH = 1'b0; bus.POP = 1'b0; bus.PC_MUX_SEL = 2'b00;
    bus.PC_COUNT = '0; bus.IMM_ADDR = '0;
    @(negedge CLK);
    step(1, 0, 0, 2'b00, 10'h000, 10'h000);
    step(1, 0, 0, 2'b00, 10'h000, 10'h000);

    step(0, 0, 0, 2'b10, 10'h000, 10'h055);
    check("lit_reset_empty", int'(bus.EMPTY), 1);
    check("lit_reset_count", int'(bus.COUNT), 0);
    check("lit_intr_vec", int'(bus.PC_DIN), 32'h3FF);
    step(0, 0, 0, 2'b00, 10'h000, 10'h055);
    check("lit_imm", int'(bus.PC_DIN), 32'h055);

    step(0, 1, 0, 2'b00, 10'h010, 10'h000);
    step(0, 1, 0, 2'b00, 10'h020, 10'h000);
    bus.POP = 1'b1; bus.PUSH = 1'b0; bus.PC_MUX_SEL = 2'b01; #1;
    check("lit_pop1_pre", int'(bus.PC_DIN), 32'h021);
    step(0, 0, 1, 2'b01, 10'h000, 10'h000);
    check("lit_pop1_count", int'(bus.COUNT), 1);
    check("lit_pop2_pre", int'(bus.PC_DIN), 32'h011);
    step(0, 0, 1, 2'b01, 10'h000, 10'h000);
    check("lit_pop2_count", int'(bus.COUNT), 0);
    check("lit_pop2_empty", int'(bus.EMPTY), 1);

    step(0, 1, 0, 2'b00, 10'h3FF, 10'h000);
    step(0, 0, 0, 2'b01, 10'h000, 10'h000);
    check("lit_wrap_ret", int'(bus.PC_DIN), 32'h001);
    step(0, 0, 1, 2'b01, 10'h000, 10'h000);

    for (int k = 1; k <= 9; k++) step(0, 1, 0, 2'b00, 10'(k), 10'h000);
    step(0, 0, 0, 2'b01, 10'h000, 10'h000);
    check("lit_full", int'(bus.FULL), 1);
    check("lit_ovf", int'(bus.OVF), 1);
`ifdef RAS_WRAP_EN
    check("lit_full_top", int'(bus.PC_DIN), 32'h00A);
`else
    check("lit_full_top", int'(bus.PC_DIN), 32'h009);
`endif
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 2'b01, 10'h000, 10'h000);
`ifdef RAS_WRAP_EN
      check("lit_drain_top", int'(bus.PC_DIN), (i < 7) ? 9 - i : 0);
`else
      check("lit_drain_top", int'(bus.PC_DIN), (i < 7) ? 8 - i : 0);
`endif
    end

    step(0, 0, 1, 2'b01, 10'h000, 10'h000);
    check("lit_unf", int'(bus.UNF), 1);
    check("lit_unf_count", int'(bus.COUNT), 0);
    step(0, 1, 1, 2'b00, 10'h040, 10'h000);
    step(0, 0, 0, 2'b01, 10'h000, 10'h000);
    check("lit_pushpop_count", int'(bus.COUNT), 1);
    check("lit_pushpop_top", int'(bus.PC_DIN), 32'h041);

    step(0, 1, 0, 2'b00, 10'h050, 10'h000);
    step(0, 1, 1, 2'b01, 10'h060, 10'h000);
    check("lit_replace_count", int'(bus.COUNT), 2);
    check("lit_replace_top", int'(bus.PC_DIN), 32'h061);
    step(0, 1, 0, 2'b01, 10'h070, 10'h000);
    check("lit_pre_rst_count", int'(bus.COUNT), 3);

    step(1, 0, 0, 2'b01, 10'h000, 10'h000);
    check("lit_rst_count", int'(bus.COUNT), 0);
    check("lit_rst_ovf", int'(bus.OVF), 0);
    check("lit_rst_unf", int'(bus.UNF), 0);
    check("lit_rst_top", int'(bus.PC_DIN), 0);
    step(0, 0, 0, 2'b11, 10'h000, 10'h123);
    check("lit_reserved_sel", int'(bus.PC_DIN), 32'h123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
